// File: rtl/vx_lsu_store_tracker_if.sv
// ----------------------------------------------------------------------------
// vx_lsu_store_tracker_if
// Purpose : groups the store-issue handshake and the store-ack channel that
//           sit between the LSU, the memory side and the store tracker.
// Signals :
//   st_issue_valid  LSU presents a store request to memory
//   st_issue_wid    warp id of the presented store
//   st_issue_ready  tracker accepts the store (combinational)
//   st_ack_valid    memory write acknowledge (always accepted)
//   st_ack_wid      warp id of the acknowledged store
// Modports: master = LSU/memory side, slave = tracker.
// ----------------------------------------------------------------------------
interface vx_lsu_store_tracker_if #(
   parameter int NW_W = 2
);
   logic            st_issue_valid;
   logic [NW_W-1:0] st_issue_wid;
   logic            st_issue_ready;
   logic            st_ack_valid;
   logic [NW_W-1:0] st_ack_wid;

   modport master (
      output st_issue_valid,
      output st_issue_wid,
      output st_ack_valid,
      output st_ack_wid,
      input  st_issue_ready
   );

   modport slave (
      input  st_issue_valid,
      input  st_issue_wid,
      input  st_ack_valid,
      input  st_ack_wid,
      output st_issue_ready
   );
endinterface

// File: rtl/vx_lsu_store_tracker.sv
// ----------------------------------------------------------------------------
// vx_lsu_store_tracker
// Purpose : counts outstanding (issued but not yet acknowledged) stores per
//           warp so the issue stage can tell when memory writes have drained.
//           Each warp owns a saturating-by-backpressure CTR_WIDTH counter:
//           a store to a warp whose counter is full is stalled.
// Ports   :
//   clk                    single clock, rising edge
//   reset                  synchronous, active-high
//   st (slave modport)     issue handshake + ack channel
//   lsu_no_pending_stores  high when every warp counter is zero
//   pending_mask           bit w high when warp w has outstanding stores
//   err_underflow          sticky: ack seen for a warp with zero count
//   perf_stores            accepted stores (perf build only, else 0)
//   perf_full_cycles       cycles stalled on a full counter (perf build only)
// Config  : define LSU_STORE_TRACKER_PERF_EN to build the perf counters;
//           otherwise both perf outputs are tied to zero.
// ----------------------------------------------------------------------------
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

module vx_lsu_store_tracker #(
   parameter int NUM_WARPS = `NUM_WARPS,
   parameter int CTR_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   vx_lsu_store_tracker_if.slave st,
   output logic                 lsu_no_pending_stores,
   output logic [NUM_WARPS-1:0] pending_mask,
   output logic                 err_underflow,
   output logic [31:0]          perf_stores,
   output logic [31:0]          perf_full_cycles
);

   localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
   localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);

   logic [NUM_WARPS-1:0][CTR_WIDTH-1:0] cnt_q, cnt_d;
   logic [NUM_WARPS-1:0]                iss_sel;   // one-hot of issue wid (0 if out of range)
   logic [NUM_WARPS-1:0]                ack_sel;   // one-hot of valid ack wid
   logic [NUM_WARPS-1:0]                full;
   logic                                err_q, err_d;
   logic                                issue_fire;

   // -------------------------------------------------------------------------
   // Warp id decode. Ids >= NUM_WARPS match no warp, so they see ready high,
   // update no counter and never raise an error.
   // -------------------------------------------------------------------------
   always_comb begin
      iss_sel = '0;
      ack_sel = '0;
      full    = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         iss_sel[w] = (st.st_issue_wid == NW_W'(w));
         ack_sel[w] = st.st_ack_valid && (st.st_ack_wid == NW_W'(w));
         full[w]    = (cnt_q[w] == CTR_MAX);
      end
   end

   // Ready depends only on the selected warp's registered count, never on
   // valid or on a same-cycle ack, so a full warp stalls even if an ack for
   // it is arriving this cycle.
   assign st.st_issue_ready = ~|(full & iss_sel);
   assign issue_fire        = st.st_issue_valid & st.st_issue_ready;

   // -------------------------------------------------------------------------
   // Counter next state. Issue and ack to the same warp cancel out; this
   // also covers the zero-count case, where the in-flight issue absorbs the
   // ack and no underflow is flagged.
   // -------------------------------------------------------------------------
   always_comb begin
      logic inc;
      logic dec;
      cnt_d = cnt_q;
      err_d = err_q;
      for (int w = 0; w < NUM_WARPS; w++) begin
         inc = issue_fire & iss_sel[w];
         dec = ack_sel[w];
         if (inc && !dec) begin
            cnt_d[w] = cnt_q[w] + CTR_ONE;
         end else if (dec && !inc) begin
            if (cnt_q[w] != '0) cnt_d[w] = cnt_q[w] - CTR_ONE;
            else                err_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Status outputs come straight from registered counters only.
   always_comb begin
      pending_mask = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         pending_mask[w] = |cnt_q[w];
      end
   end

   assign lsu_no_pending_stores = ~|pending_mask;
   assign err_underflow         = err_q;

   // -------------------------------------------------------------------------
   // Performance counters (free-running, wrap modulo 2^32).
   // -------------------------------------------------------------------------
`ifdef LSU_STORE_TRACKER_PERF_EN
   logic [31:0] perf_stores_q,      perf_stores_d;
   logic [31:0] perf_full_cycles_q, perf_full_cycles_d;

   always_comb begin
      perf_stores_d      = perf_stores_q;
      perf_full_cycles_d = perf_full_cycles_q;
      if (issue_fire)                                perf_stores_d      = perf_stores_q + 32'd1;
      if (st.st_issue_valid && !st.st_issue_ready)   perf_full_cycles_d = perf_full_cycles_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stores_q      <= '0;
         perf_full_cycles_q <= '0;
      end else begin
         perf_stores_q      <= perf_stores_d;
         perf_full_cycles_q <= perf_full_cycles_d;
      end
   end

   assign perf_stores      = perf_stores_q;
   assign perf_full_cycles = perf_full_cycles_q;
`else
   assign perf_stores      = '0;
   assign perf_full_cycles = '0;
`endif

endmodule

// File: tb/tb_vx_lsu_store_tracker.sv
module tb_vx_lsu_store_tracker;
   localparam int NW    = 5;            // 3-bit ids, so 5..7 are out of range
   localparam int CW    = 4;
   localparam int NW_W  = 3;
   localparam int CMAX  = (1 << CW) - 1;

   typedef struct {
      logic          rdy;
      logic [NW-1:0] mask;
      logic          nop;
      logic          err;
      logic [31:0]   ps;
      logic [31:0]   pf;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic          no_pend;
   logic [NW-1:0] pmask;
   logic          err_uf;
   logic [31:0]   perf_st, perf_fc;

   vx_lsu_store_tracker_if #(.NW_W(NW_W)) tif ();

   vx_lsu_store_tracker #(.NUM_WARPS(NW), .CTR_WIDTH(CW)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .st                    (tif),
      .lsu_no_pending_stores (no_pend),
      .pending_mask          (pmask),
      .err_underflow         (err_uf),
      .perf_stores           (perf_st),
      .perf_full_cycles      (perf_fc)
   );

   always #5 clk = ~clk;

   // reference model state: plain per-warp outstanding counts
   int          m_cnt [NW];
   bit          m_err;
   int unsigned m_ps, m_pf;
   exp_t        scb [$];
   int          total  = 0;
   int          passed = 0;
   bit          stim_done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
   endtask

   // monitor: compares whatever the DUT shows against the queued expectation
   always @(negedge clk) begin
      if (scb.size() > 0) begin
         exp_t e;
         e = scb.pop_front();
         chk("st_issue_ready",   32'(tif.st_issue_ready), 32'(e.rdy));
         chk("pending_mask",     32'(pmask),              32'(e.mask));
         chk("no_pending",       32'(no_pend),            32'(e.nop));
         chk("err_underflow",    32'(err_uf),             32'(e.err));
         chk("perf_stores",      perf_st,                 e.ps);
         chk("perf_full_cycles", perf_fc,                 e.pf);
      end
   end

   // one clock of stimulus; expectation pushed before the edge, model
   // advanced after it
   task automatic cyc(input logic iv, input int iw, input logic av, input int aw, input logic r);
      exp_t e;
      bit   in_rng, rdy, fire;
      reset              = r;
      tif.st_issue_valid = iv;
      tif.st_issue_wid   = NW_W'(iw);
      tif.st_ack_valid   = av;
      tif.st_ack_wid     = NW_W'(aw);
      in_rng = (iw < NW);
      rdy    = !(in_rng && m_cnt[in_rng ? iw : 0] == CMAX);
      fire   = iv && rdy;
      if (!r) begin
         e.rdy  = rdy;
         e.mask = '0;
         for (int w = 0; w < NW; w++) e.mask[w] = (m_cnt[w] != 0);
         e.nop  = (e.mask == '0);
         e.err  = m_err;
`ifdef LSU_STORE_TRACKER_PERF_EN
         e.ps = m_ps;
         e.pf = m_pf;
`else
         e.ps = 0;
         e.pf = 0;
`endif
         scb.push_back(e);
      end
      @(posedge clk);
      if (r) begin
         for (int w = 0; w < NW; w++) m_cnt[w] = 0;
         m_err = 0; m_ps = 0; m_pf = 0;
      end else begin
         if (fire) m_ps++;
         if (iv && !rdy) m_pf++;
         if (av && aw < NW) begin
            if (fire && iw == aw) ;              // cancels
            else if (m_cnt[aw] > 0) m_cnt[aw]--;
            else m_err = 1;
         end
         if (fire && in_rng && !(av && aw == iw)) m_cnt[iw]++;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   initial begin
      int iw, aw, ip, ap;
      logic iv, av, r;
      // reset then idle
      cyc(0, 0, 0, 0, 1);
      idle(5);
      // single store warp 2, ack five cycles later
      cyc(1, 2, 0, 0, 0);
      idle(4);
      cyc(0, 0, 1, 2, 0);
      idle(2);
      // fill warp 1, hold valid while full, then probe warp 0
      for (int i = 0; i < 15; i++) cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++)  cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 0);   // full warp: stall while ack drains one
      cyc(1, 6, 1, 7, 0);   // out-of-range ids
      // same-cycle issue+ack for warp 3 with count 1
      cyc(0, 0, 0, 0, 1);
      cyc(1, 3, 0, 0, 0);
      cyc(1, 3, 1, 3, 0);
      idle(2);
      // underflow, sticky, cleared by reset
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0);
      idle(3);
      cyc(1, 4, 1, 4, 0);   // issue+ack on empty warp: no error change
      cyc(0, 0, 0, 0, 1);
      cyc(1, 2, 1, 2, 0);   // zero count absorbed by same-cycle issue
      idle(2);
      // mid-operation reset discards counts
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 1, 1, 1);
      idle(1);
      cyc(0, 0, 1, 0, 0);
      idle(2);
      // randomized phases: fill-heavy on few warps, then drain-heavy
      for (int i = 0; i < 3000; i++) begin
         bit fill;
         fill = ((i / 300) % 2) == 0;
         ip = fill ? 80 : 25;
         ap = fill ? 20 : 70;
         iv = ($urandom_range(0, 99) < ip);
         av = ($urandom_range(0, 99) < ap);
         iw = ($urandom_range(0, 9) < 8) ? (fill ? $urandom_range(0, 1) : $urandom_range(0, 4))
                                         : $urandom_range(5, 7);
         aw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
         r  = ($urandom_range(0, 599) == 0);
         cyc(iv, iw, av, aw, r);
      end
      idle(1);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(scb.size()), 32'd0);
      stim_done = 1'b1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // hard bound so the run always ends
   initial begin
      #2000000;
      if (!stim_done) begin
         $display("FAIL timeout: got running expected finished");
         $fatal(1, "timeout");
      end
   end
endmodule
